// File: rtl/sr_mul_arbiter_if.sv
// ---------------------------------------------------------------------------
// sr_mul_arbiter_if
//
// Signal bundle between the two multiply requesters, the shared pipelined
// multiplier and the sr_mul_arbiter sequencer.
//
// Handshake semantics (all valid/ready pairs in this bundle):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. The source keeps valid and its payload stable until that transfer;
//   ready may depend combinationally on valid in the same cycle.
//
// Groups:
//   req0_* / req1_*  requester -> arbiter : valid, a, b, tag ; ready back
//   rsp0_* / rsp1_*  arbiter -> requester : valid, data, tag ; ready back
//   mul_*            arbiter <-> multiplier: valid, a, b out ; result in
//   busy             arbiter status: something in flight or queued
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus the multiplier)
// ---------------------------------------------------------------------------
interface sr_mul_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [XLEN-1:0]  req0_a;
    logic [XLEN-1:0]  req0_b;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [XLEN-1:0]  req1_a;
    logic [XLEN-1:0]  req1_b;
    logic [TAG_W-1:0] req1_tag;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [XLEN-1:0]  rsp0_data;
    logic [TAG_W-1:0] rsp0_tag;

    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [XLEN-1:0]  rsp1_data;
    logic [TAG_W-1:0] rsp1_tag;

    logic             mul_valid;
    logic [XLEN-1:0]  mul_a;
    logic [XLEN-1:0]  mul_b;
    logic [XLEN-1:0]  mul_result;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_tag,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_tag,
        output req1_ready,
        output rsp0_valid, rsp0_data, rsp0_tag,
        input  rsp0_ready,
        output rsp1_valid, rsp1_data, rsp1_tag,
        input  rsp1_ready,
        output mul_valid, mul_a, mul_b,
        input  mul_result,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_tag,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_tag,
        input  req1_ready,
        input  rsp0_valid, rsp0_data, rsp0_tag,
        output rsp0_ready,
        input  rsp1_valid, rsp1_data, rsp1_tag,
        output rsp1_ready,
        input  mul_valid, mul_a, mul_b,
        output mul_result,
        input  busy
    );
endinterface

// File: rtl/sr_mul_arbiter.sv
// ---------------------------------------------------------------------------
// sr_mul_arbiter
//
// Round-robin arbiter and sequencer sharing one fixed-latency pipelined
// multiplier (signed XLEN x XLEN, low word kept) between two requesters:
// port 0 (core execute stage) and port 1 (coprocessor / debug engine).
//
// Each accepted operation is tagged with its owner and walks a MUL_LAT-deep
// tracker alongside the multiplier pipe. When it leaves the tracker, the
// multiplier result is written, together with the requester tag, into the
// owner's first-word-fall-through response FIFO.
//
// A per-port credit counter (ops in flight + FIFO entries) stops a port from
// issuing once it could overfill its FIFO, so captures never find the FIFO
// full and the multiplier pipe never has to stall.
//
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset; clears credits, tracker,
//            FIFOs; round-robin pointer points at port 1 so port 0 wins
//            the first tie
//   bus    - sr_mul_arbiter_if.slave: req0/req1 request channels,
//            rsp0/rsp1 response channels, mul_* multiplier interface,
//            busy status
// ---------------------------------------------------------------------------
module sr_mul_arbiter #(
    parameter int XLEN      = 32,
    parameter int MUL_LAT   = 2,
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    sr_mul_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int LAST  = MUL_LAT - 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RSP_DEPTH);

    // -----------------------------------------------------------------------
    // Port-indexed views of the bus so the per-port logic can be looped
    // -----------------------------------------------------------------------
    logic [1:0]       req_valid;
    logic [XLEN-1:0]  req_a   [2];
    logic [XLEN-1:0]  req_b   [2];
    logic [TAG_W-1:0] req_tag [2];
    logic [1:0]       rsp_ready;

    assign req_valid  = {bus.req1_valid, bus.req0_valid};
    assign req_a[0]   = bus.req0_a;
    assign req_a[1]   = bus.req1_a;
    assign req_b[0]   = bus.req0_b;
    assign req_b[1]   = bus.req1_b;
    assign req_tag[0] = bus.req0_tag;
    assign req_tag[1] = bus.req1_tag;
    assign rsp_ready  = {bus.rsp1_ready, bus.rsp0_ready};

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] cnt [2];        // credits used: in flight + queued
    logic             last_grant;     // port that won the most recent grant

    logic [MUL_LAT-1:0] trk_valid;
    logic [MUL_LAT-1:0] trk_owner;
    logic [TAG_W-1:0]   trk_tag [MUL_LAT];

    logic [XLEN-1:0]  fifo_data [2][RSP_DEPTH];
    logic [TAG_W-1:0] fifo_tag  [2][RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr    [2];
    logic [PTR_W-1:0] rd_ptr    [2];
    logic [CNT_W-1:0] fifo_cnt  [2];

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    logic [1:0]       elig;
    logic [1:0]       grant;
    logic [1:0]       cap_en;
    logic [1:0]       rsp_valid;
    logic [1:0]       pop;
    logic [XLEN-1:0]  issue_a;
    logic [XLEN-1:0]  issue_b;
    logic [TAG_W-1:0] issue_tag;

    // Eligibility looks at the registered credit count only, so a response
    // popped this cycle frees its credit from the next cycle on. rst_n gates
    // it so no request is acknowledged while reset is held.
    always_comb begin
        elig = '0;
        for (int p = 0; p < 2; p++) begin
            elig[p] = rst_n & req_valid[p] & (cnt[p] < CNT_FULL);
        end
    end

    // Single grant per cycle; on a tie the port that did not win last time
    // is served.
    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        issue_a   = '0;
        issue_b   = '0;
        issue_tag = '0;
        if (grant[0]) begin
            issue_a   = req_a[0];
            issue_b   = req_b[0];
            issue_tag = req_tag[0];
        end else if (grant[1]) begin
            issue_a   = req_a[1];
            issue_b   = req_b[1];
            issue_tag = req_tag[1];
        end
    end

    // The last tracker stage lines up with mul_result: its owner decides
    // which FIFO takes the product at this edge.
    always_comb begin
        cap_en    = '0;
        rsp_valid = '0;
        pop       = '0;
        for (int p = 0; p < 2; p++) begin
            cap_en[p]    = trk_valid[LAST] & (trk_owner[LAST] == 1'(p));
            rsp_valid[p] = (fifo_cnt[p] != '0);
            pop[p]       = rsp_valid[p] & rsp_ready[p];
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

    // -----------------------------------------------------------------------
    // Credit counters: +1 on request handshake, -1 on response handshake
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                case ({grant[p], pop[p]})
                    2'b10:   cnt[p] <= cnt[p] + CNT_W'(1);
                    2'b01:   cnt[p] <= cnt[p] - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Ownership tracker: mirrors the multiplier pipe, never stalls
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_valid <= '0;
            trk_owner <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                trk_tag[i] <= '0;
            end
        end else begin
            trk_valid[0] <= |grant;
            trk_owner[0] <= grant[1];
            trk_tag[0]   <= issue_tag;
            for (int i = 1; i < MUL_LAT; i++) begin
                trk_valid[i] <= trk_valid[i-1];
                trk_owner[i] <= trk_owner[i-1];
                trk_tag[i]   <= trk_tag[i-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Response FIFOs (first-word fall-through). Capture and pop in the same
    // cycle are both performed; the credit scheme guarantees a capture never
    // meets a full FIFO. Pointers wrap naturally since RSP_DEPTH is 2^n.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr[p]   <= '0;
                rd_ptr[p]   <= '0;
                fifo_cnt[p] <= '0;
                for (int i = 0; i < RSP_DEPTH; i++) begin
                    fifo_data[p][i] <= '0;
                    fifo_tag[p][i]  <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (cap_en[p]) begin
                    fifo_data[p][wr_ptr[p]] <= bus.mul_result;
                    fifo_tag[p][wr_ptr[p]]  <= trk_tag[LAST];
                    wr_ptr[p]               <= wr_ptr[p] + PTR_W'(1);
                end
                if (pop[p]) begin
                    rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
                end
                case ({cap_en[p], pop[p]})
                    2'b10:   fifo_cnt[p] <= fifo_cnt[p] + CNT_W'(1);
                    2'b01:   fifo_cnt[p] <= fifo_cnt[p] - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    assign bus.mul_valid  = |grant;
    assign bus.mul_a      = issue_a;
    assign bus.mul_b      = issue_b;

    assign bus.rsp0_valid = rsp_valid[0];
    assign bus.rsp0_data  = fifo_data[0][rd_ptr[0]];
    assign bus.rsp0_tag   = fifo_tag[0][rd_ptr[0]];
    assign bus.rsp1_valid = rsp_valid[1];
    assign bus.rsp1_data  = fifo_data[1][rd_ptr[1]];
    assign bus.rsp1_tag   = fifo_tag[1][rd_ptr[1]];

    assign bus.busy       = (|trk_valid) | (|rsp_valid);

endmodule
